rv_csr_exec: RTL
================

# rv_csr_exec

Executes Zicsr instructions (CSRRW/CSRRS/CSRRC and their immediate forms) on behalf of the core pipeline. It is the initiator side of the CSR-file interface (`csr`, `load`, `store`, `store_value` → `sigill`, `load_value`). It sequences the read and write phases over separate cycles and computes the read-modify-write value. It returns the old CSR value for `rd` or an illegal-instruction indication through a valid/ready result handshake.

## Interface
- `rv64`, default 1: 1 selects RV64 (xlen = 64), 0 selects RV32 (xlen = 32).

Ports:
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `inst_valid` in 1: offered instruction is valid.
- `inst_ready` out 1: block accepts an instruction.
- `inst` in 32: instruction word.
- `rs1_value` in xlen: value of `inst[19:15]`, sampled at accept.
- `csr` out 12: CSR address to the CSR file.
- `load` out 1: read strobe to the CSR file.
- `store` out 1: write strobe to the CSR file.
- `store_value` out xlen: write data to the CSR file.
- `load_value` in xlen: combinational read data from the CSR file.
- `sigill` in 1: combinational reject from the CSR file.
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer takes the result.
- `rd` out 5: destination register.
- `rd_write` out 1: write `rd_value` to `rd`.
- `rd_value` out xlen: old CSR value.
- `illegal` out 1: raise an illegal-instruction exception.

## Operation
- Decode at accept:
  - Legal only if `inst[6:0]` = 7'b1110011 and funct3 ∈ {001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI}. Anything else is illegal.
  - `src` = `rs1_value` for funct3[2]=0; otherwise the zero-extended `inst[19:15]` (uimm).
  - `do_read` = 0 only for RW/RWI with rd = 0; otherwise 1.
  - `do_write` = 0 for RS/RSI/RC/RCI with `inst[19:15]` = 0; otherwise 1.
  - If `do_write` and `csr[11:10]` = 2'b11, the instruction is illegal (read-only CSR) and no strobe is issued.
- Write value:
  - RW: `src`.
  - RS: `old | src`.
  - RC: `old & ~src`.
  - `old` is the `load_value` captured in READ.
- FSM states IDLE, READ, WRITE, DONE. Transitions are evaluated at the clock edge.
  - IDLE: `inst_ready`=1. On `inst_valid`:
    - illegal → DONE.
    - else `do_read` → READ.
    - else → WRITE.
  - READ: `load`=1 and `csr` driven for one cycle. Capture `load_value` into `old`. If `sigill`: set illegal and go to DONE. Otherwise go to WRITE if `do_write`, else DONE.
  - WRITE: `store`=1 with `store_value` for one cycle. Sample `sigill`; if set, mark illegal. Go to DONE.
  - DONE: `result_valid`=1. Outputs are held stable until `result_ready`, then go to IDLE.
- Result fields:
  - `rd_write` = !illegal && `do_read` && rd≠0.
  - `rd_value` = `old`, or 0 if no read was done.
  - `illegal` as accumulated above.
- `load` and `store` are never asserted in the same cycle. Both are 0 outside READ/WRITE. `store_value` = 0 outside WRITE.
- `csr` holds the latched `inst[31:20]` from accept until the next accept.

## Timing
- Reset (clock edge with `reset`=1):
  - State → IDLE.
  - `result_valid`, `load`, `store`, `rd_write`, `illegal` = 0.
  - `csr`, `rd`, `rd_value`, `store_value` = 0.
  - `inst_ready`=1 from the following cycle.
- Reset mid-operation: in-flight instruction is dropped. Strobes are low in the cycle after the reset edge; no partial result is produced.
- Latency from accept edge to `result_valid`, with `result_ready` held high:
  - read+write: 3 cycles.
  - read-only or write-only: 2 cycles.
  - illegal at decode: 1 cycle.
- Throughput: one instruction per (latency + 1) cycles. `inst_ready`=0 outside IDLE; no overlap.
- DONE with `result_ready`=0 stalls indefinitely with all result outputs constant.

## Test plan
- CSRRS x5, 0xC00, x0; `load_value`=0x1234:
  - `load` high exactly 1 cycle, `store` never high.
  - Result 2 cycles after accept: `rd_write`=1, `rd`=5, `rd_value`=0x1234.
- CSRRC x6, 0x340, x7; `load_value`=0xF0, `rs1_value`=0x30:
  - READ then WRITE.
  - `store_value`=0xC0.
  - `rd_value`=0xF0, `illegal`=0.
- CSRRW x0, 0x301, x1; CSR file asserts `sigill` on store:
  - No `load`; `store` 1 cycle.
  - Result: `illegal`=1, `rd_write`=0.
- CSRRWI x1, 0xC01, 5:
  - Read-only CSR → `illegal`=1 after 1 cycle, no strobes.
  - funct3=100 → same response.
- Backpressure: hold `result_ready`=0 for 4 cycles in DONE:
  - Outputs stable; `inst_ready`=0.
  - On release, IDLE and next instruction accepted.
- Assert `reset` during WRITE:
  - Next cycle `store`=0, `result_valid`=0, `inst_ready`=1.
  - Subsequent CSRRS completes normally.

Source files
------------

// File: rtl/rv_csr_exec.sv
// Zicsr executor: decodes CSRRW/S/C (+ immediate forms), sequences READ and WRITE
// phases against the CSR file, and returns the old value through a valid/ready result.
module rv_csr_exec #(
    parameter bit rv64 = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      inst_valid,
    output logic                      inst_ready,
    input  logic [31:0]               inst,
    input  logic [(rv64 ? 64 : 32)-1:0] rs1_value,
    output logic [11:0]               csr,
    output logic                      load,
    output logic                      store,
    output logic [(rv64 ? 64 : 32)-1:0] store_value,
    input  logic [(rv64 ? 64 : 32)-1:0] load_value,
    input  logic                      sigill,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [4:0]                rd,
    output logic                      rd_write,
    output logic [(rv64 ? 64 : 32)-1:0] rd_value,
    output logic                      illegal
);
    localparam int unsigned xlen = rv64 ? 64 : 32;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_t;

    state_t            state;
    logic [1:0]        op;
    logic [xlen-1:0]   src;
    logic [xlen-1:0]   old;
    logic              do_read;
    logic              do_write;

    logic [2:0]        dec_funct3;
    logic              dec_do_read;
    logic              dec_do_write;
    logic              dec_illegal;
    logic [xlen-1:0]   dec_src;
    logic [xlen-1:0]   new_value;

    assign inst_ready = (state == StIdle);

    always_comb begin
        dec_funct3   = inst[14:12];
        dec_do_read  = !((dec_funct3[1:0] == 2'b01) && (inst[11:7] == 5'd0));
        dec_do_write = (dec_funct3[1:0] == 2'b01) || (inst[19:15] != 5'd0);
        // funct3 000 and 100 both have low bits 00; read-only CSRs reject any write.
        dec_illegal  = (inst[6:0] != 7'b1110011) || (dec_funct3[1:0] == 2'b00) ||
                       (dec_do_write && (inst[31:30] == 2'b11));
        dec_src      = dec_funct3[2] ? {{(xlen-5){1'b0}}, inst[19:15]} : rs1_value;
    end

    always_comb begin
        new_value = src;
        case (op)
            2'b10:   new_value = load_value | src;
            2'b11:   new_value = load_value & ~src;
            default: new_value = src;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= StIdle;
            op           <= 2'b00;
            src          <= '0;
            old          <= '0;
            do_read      <= 1'b0;
            do_write     <= 1'b0;
            csr          <= 12'd0;
            load         <= 1'b0;
            store        <= 1'b0;
            store_value  <= '0;
            result_valid <= 1'b0;
            rd           <= 5'd0;
            rd_write     <= 1'b0;
            rd_value     <= '0;
            illegal      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (inst_valid) begin
                        csr      <= inst[31:20];
                        rd       <= inst[11:7];
                        op       <= dec_funct3[1:0];
                        src      <= dec_src;
                        do_read  <= dec_do_read;
                        do_write <= dec_do_write;
                        rd_write <= 1'b0;
                        rd_value <= '0;
                        illegal  <= 1'b0;
                        if (dec_illegal) begin
                            state        <= StDone;
                            result_valid <= 1'b1;
                            illegal      <= 1'b1;
                        end else if (dec_do_read) begin
                            state <= StRead;
                            load  <= 1'b1;
                        end else begin
                            // Write-only is always RW/RWI, so the write value is src itself.
                            state       <= StWrite;
                            store       <= 1'b1;
                            store_value <= dec_src;
                        end
                    end
                end
                StRead: begin
                    load <= 1'b0;
                    old  <= load_value;
                    if (sigill) begin
                        state        <= StDone;
                        result_valid <= 1'b1;
                        illegal      <= 1'b1;
                        rd_value     <= load_value;
                    end else if (do_write) begin
                        state       <= StWrite;
                        store       <= 1'b1;
                        store_value <= new_value;
                    end else begin
                        state        <= StDone;
                        result_valid <= 1'b1;
                        rd_value     <= load_value;
                        rd_write     <= (rd != 5'd0);
                    end
                end
                StWrite: begin
                    store        <= 1'b0;
                    store_value  <= '0;
                    state        <= StDone;
                    result_valid <= 1'b1;
                    illegal      <= sigill;
                    rd_write     <= !sigill && do_read && (rd != 5'd0);
                    rd_value     <= do_read ? old : '0;
                end
                StDone: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule
